// File: rtl/sub_div_pkg.sv
// sub_div_pkg: shared state encoding and counter sizing for the sequential divider
package sub_div_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  function automatic int cnt_width(input int width);
    return ($clog2(width) < 1) ? 1 : $clog2(width);
  endfunction
endpackage

// File: rtl/sub_div_seq_sub.sv
// Sub: a - b as a + ~b + 1 with selectable carry-prefix network (0 serial, 1 Brent-Kung, 2 Sklansky)
module Sub #(
  parameter int width = 8,
  parameter int speed = 0
) (
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  output logic [width-1:0] d_o
);
  localparam int LG = $clog2(width);
  logic [width-1:0] p, g_n, p_n, c;
  // Node 0 is the constant carry-in; node i>0 carries bit i-1, so prefix i is the carry into bit i.
  assign p   = a_i ^ ~b_i;
  assign g_n = {a_i[width-2:0] & ~b_i[width-2:0], 1'b1};
  assign p_n = {p[width-2:0], 1'b0};
  function automatic logic [width-1:0] carries(input logic [width-1:0] g0, input logic [width-1:0] p0);
    logic [width-1:0] g, pp;
    int j;
    g  = g0;
    pp = p0;
    if (speed == 0) begin
      for (int i = 1; i < width; i++) begin
        g[i]  = g[i] | (pp[i] & g[i-1]);
        pp[i] = pp[i] & pp[i-1];
      end
    end else if (speed == 1) begin
      for (int l = 0; l < LG; l++)
        for (int i = 0; i < width; i++)
          if ((i + 1) % (2 << l) == 0) begin
            j     = i - (1 << l);
            g[i]  = g[i] | (pp[i] & g[j]);
            pp[i] = pp[i] & pp[j];
          end
      for (int l = LG - 1; l >= 0; l--)
        for (int i = 0; i < width; i++)
          if ((i + 1) % (2 << l) == (1 << l) && i >= (2 << l)) begin
            j     = i - (1 << l);
            g[i]  = g[i] | (pp[i] & g[j]);
            pp[i] = pp[i] & pp[j];
          end
    end else begin
      for (int l = 0; l < LG; l++)
        for (int i = 0; i < width; i++)
          if (((i >> l) & 1) == 1) begin
            j     = ((i >> l) << l) - 1;
            g[i]  = g[i] | (pp[i] & g[j]);
            pp[i] = pp[i] & pp[j];
          end
    end
    return g;
  endfunction
  assign c   = carries(g_n, p_n);
  assign d_o = p ^ c;
endmodule

// File: rtl/sub_div_seq.sv
// sub_div_seq: restoring unsigned divider, one trial subtraction per cycle through a shared Sub
module sub_div_seq
  import sub_div_pkg::*;
#(
  parameter int width = 8,
  parameter int speed = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [width-1:0] A_i,
  input  logic [width-1:0] B_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [width-1:0] Q_o,
  output logic [width-1:0] R_o,
  output logic             div_zero_o
);
  localparam int CW = cnt_width(width);
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [width-1:0]  quot_q, quot_d, div_q, div_d;
  logic [width:0]    rem_q, rem_d, shifted, diff;
  logic              dz_q, dz_d;
  assign shifted = {rem_q[width-1:0], quot_q[width-1]};
  Sub #(.width(width + 1), .speed(speed)) u_sub (
    .a_i(shifted),
    .b_i({1'b0, div_q}),
    .d_o(diff)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    div_d   = div_q;
    dz_d    = dz_q;
    if (state_q == IDLE && in_valid_i) begin
      state_d = BUSY;
      quot_d  = A_i;
      rem_d   = '0;
      div_d   = B_i;
      dz_d    = (B_i == '0);
      cnt_d   = CW'(width - 1);
    end else if (state_q == BUSY) begin
      rem_d   = diff[width] ? shifted : diff;
      quot_d  = {quot_q[width-2:0], ~diff[width]};
      cnt_d   = cnt_q - CW'(1);
      state_d = (cnt_q == '0) ? DONE : BUSY;
    end else if (state_q == DONE && out_ready_i) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
    end
  end
  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign Q_o         = quot_q;
  assign R_o         = rem_q[width-1:0];
  assign div_zero_o  = dz_q;
endmodule

// File: tb/tb_sub_div_seq.sv
// tb_sub_div_seq: directed checks of the sequential divider at width 8/4/16 across all prefix styles
module tb_sub_div_seq;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, out_ready = 0, in_ready, out_valid, dz;
  logic [7:0] a = 0, b = 0, q, r;
  logic v2 = 0, r2 = 0;
  logic [3:0] a4 = 0, b4 = 0, q4, r4;
  logic [15:0] a16 = 0, b16 = 0, q16, r16;
  logic rdy4, ov4, dz4, rdy16, ov16, dz16;
  int n_vec = 0, n_err = 0, seen;
  always #5 clk = ~clk;
  sub_div_seq #(.width(8), .speed(0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .A_i(a), .B_i(b), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .Q_o(q), .R_o(r), .div_zero_o(dz)
  );
  sub_div_seq #(.width(4), .speed(1)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v2), .in_ready_o(rdy4),
    .A_i(a4), .B_i(b4), .out_valid_o(ov4), .out_ready_i(r2),
    .Q_o(q4), .R_o(r4), .div_zero_o(dz4)
  );
  sub_div_seq #(.width(16), .speed(2)) dut16 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v2), .in_ready_o(rdy16),
    .A_i(a16), .B_i(b16), .out_valid_o(ov16), .out_ready_i(r2),
    .Q_o(q16), .R_o(r16), .div_zero_o(dz16)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic op(input logic [7:0] ia, ib, eq, er, input logic ez, input int hold, input bit junk);
    int lat = 0;
    chk("in_ready_idle", in_ready, 1);
    a = ia; b = ib; in_valid = 1; out_ready = (hold == 0);
    tick();
    chk("accepted", in_ready, 0);
    if (!junk) in_valid = 0;
    while (!out_valid && lat < 40) begin
      if (junk) begin a = 8'($urandom); b = 8'($urandom); end
      tick();
      lat++;
    end
    chk("latency", lat, 8);
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_q", q, eq);
      chk("hold_r", r, er);
      chk("hold_dz", dz, ez);
      if (junk) begin a = 8'($urandom); b = 8'($urandom); end
      tick();
    end
    chk("q", q, eq);
    chk("r", r, er);
    chk("dz", dz, ez);
    chk("out_valid", out_valid, 1);
    out_ready = 1;
    tick();
    chk("valid_drop", out_valid, 0);
    chk("ready_back", in_ready, 1);
  endtask
  task automatic aux(input logic [3:0] ia4, ib4, eq4, er4, input logic ez4,
                     input logic [15:0] ia16, ib16, eq16, er16, input logic ez16);
    int l4 = -1, l16 = -1;
    a4 = ia4; b4 = ib4; a16 = ia16; b16 = ib16; v2 = 1; r2 = 0;
    tick();
    v2 = 0;
    for (int t = 1; t <= 40 && (l4 < 0 || l16 < 0); t++) begin
      tick();
      if (ov4 && l4 < 0) begin
        l4 = t;
        chk("w4_q", q4, eq4); chk("w4_r", r4, er4); chk("w4_dz", dz4, ez4);
      end
      if (ov16 && l16 < 0) begin
        l16 = t;
        chk("w16_q", q16, eq16); chk("w16_r", r16, er16); chk("w16_dz", dz16, ez16);
      end
    end
    chk("w4_latency", l4, 4);
    chk("w16_latency", l16, 16);
    r2 = 1;
    tick();
    chk("w4_ready_back", rdy4, 1);
    chk("w16_ready_back", rdy16, 1);
    r2 = 0;
  endtask
  initial begin
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_dz", dz, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    op(8'd100, 8'd7, 8'd14, 8'd2, 0, 0, 0);
    op(8'd255, 8'd1, 8'd255, 8'd0, 0, 0, 0);
    op(8'd3, 8'd200, 8'd0, 8'd3, 0, 0, 0);
    op(8'd5, 8'd0, 8'd255, 8'd5, 1, 0, 0);
    op(8'd255, 8'd255, 8'd1, 8'd0, 0, 0, 0);
    op(8'd200, 8'd13, 8'd15, 8'd5, 0, 3, 0);
    op(8'd100, 8'd7, 8'd14, 8'd2, 0, 2, 1);
    op(8'd37, 8'd6, 8'd6, 8'd1, 0, 0, 0);
    a = 8'd200; b = 8'd3; in_valid = 1; out_ready = 1;
    tick();
    in_valid = 0;
    repeat (3) tick();
    rst_n = 0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_q", q, 0);
    chk("abort_r", r, 0);
    chk("abort_dz", dz, 0);
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (12) begin
      tick();
      if (out_valid) seen++;
    end
    chk("no_result_after_abort", seen, 0);
    op(8'd9, 8'd4, 8'd2, 8'd1, 0, 0, 0);
    aux(4'd13, 4'd4, 4'd3, 4'd1, 0, 16'd50000, 16'd123, 16'd406, 16'd62, 0);
    aux(4'd15, 4'd1, 4'd15, 4'd0, 0, 16'd65535, 16'd255, 16'd257, 16'd0, 0);
    aux(4'd7, 4'd0, 4'd15, 4'd7, 1, 16'd1000, 16'd0, 16'd65535, 16'd1000, 1);
    aux(4'd2, 4'd9, 4'd0, 4'd2, 0, 16'd12345, 16'd12346, 16'd0, 16'd12345, 0);
    aux(4'd11, 4'd3, 4'd3, 4'd2, 0, 16'd60000, 16'd7, 16'd8571, 16'd3, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
